// File: rtl/srl_sra_iter_if.sv
// rtl/srl_sra_iter_if.sv - start/busy/done handshake and operand bus for the iterative right shifter
interface srl_sra_iter_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic             arith;
    logic [WIDTH-1:0] A;
    logic [SHW-1:0]   s;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] B;

    modport master (
        output start, arith, A, s, flush,
        input  busy, done, B
    );

    modport slave (
        input  start, arith, A, s, flush,
        output busy, done, B
    );
endinterface

// File: rtl/srl_sra_iter.sv
// rtl/srl_sra_iter.sv - multi-cycle SRL/SRA, one shift-amount bit per cycle (16 at accept, then 8/4/2/1)
module srl_sra_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    srl_sra_iter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_cnt;
    logic             r_fill;
    logic [SHW-2:0]   r_s;

    logic             w_accept;
    logic             w_fill;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_step;

    assign w_accept = (r_state != SHIFT) && bus.start && !bus.flush;
    assign w_fill   = bus.arith & bus.A[WIDTH-1];
    // The 16-bit stage is resolved at accept so SHIFT only walks the lower four bits.
    assign w_load   = bus.s[SHW-1] ? {{(WIDTH/2){w_fill}}, bus.A[WIDTH-1:WIDTH/2]} : bus.A;

    always_comb begin
        w_shifted = r_work;
        case (r_cnt)
            2'd3:    w_shifted = {{8{r_fill}}, r_work[WIDTH-1:8]};
            2'd2:    w_shifted = {{4{r_fill}}, r_work[WIDTH-1:4]};
            2'd1:    w_shifted = {{2{r_fill}}, r_work[WIDTH-1:2]};
            default: w_shifted = {r_fill, r_work[WIDTH-1:1]};
        endcase
    end

    assign w_step = r_s[r_cnt] ? w_shifted : r_work;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_accept ? SHIFT : IDLE;
            SHIFT: begin
                if (bus.flush)
                    w_state_nxt = IDLE;
                else if (r_cnt == 2'd0)
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = w_accept ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_fill  <= 1'b0;
            r_s     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_fill <= w_fill;
                r_s    <= bus.s[SHW-2:0];
                r_work <= w_load;
                r_cnt  <= 2'd3;
            end else if (r_state == SHIFT && !bus.flush) begin
                r_work <= w_step;
                r_cnt  <= r_cnt - 2'd1;
                if (r_cnt == 2'd0)
                    r_b <= w_step;
            end
        end
    end

    assign bus.busy = (r_state == SHIFT);
    assign bus.done = (r_state == DONE);
    assign bus.B    = r_b;
endmodule

// File: tb/tb_srl_sra_iter.sv
// tb/tb_srl_sra_iter.sv - randomized and directed bench for srl_sra_iter against a shift-operator reference
module tb_srl_sra_iter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    srl_sra_iter_if bus ();

    srl_sra_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh, input logic ar);
        if (ar)
            return $unsigned($signed(a) >>> sh);
        return a >> sh;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Start in cycle n, then check busy/done every cycle and B at n+5; operands are scrambled after accept.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [4:0] sh, input logic ar);
        logic [31:0] exp;
        exp = ref_shift(a, sh, ar);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.s     = sh;
        bus.arith = ar;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.A     = $urandom;
                bus.s     = 5'($urandom);
                bus.arith = ~ar;
            end
            chk({tag, "_busy"}, 32'(bus.busy), 32'(k < 5));
            chk({tag, "_done"}, 32'(bus.done), 32'(k == 5));
            if (k == 5)
                chk({tag, "_B"}, bus.B, exp);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [4:0]  sh;
        logic        ar;
        logic [31:0] exp;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.arith = 1'b0;
        bus.A     = '0;
        bus.s     = '0;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_B", bus.B, 32'd0);
        rst_n = 1'b1;

        do_op("srl8", 32'h3ff98732, 5'd8, 1'b0);
        do_op("sra31", 32'h80000001, 5'd31, 1'b1);
        do_op("srl31", 32'h80000001, 5'd31, 1'b0);
        do_op("sra4", 32'h7ffffff0, 5'd4, 1'b1);
        do_op("s0", 32'hdeadbeef, 5'd0, 1'b1);

        for (int i = 0; i < 40; i++)
            do_op("rnd", $urandom, 5'($urandom), 1'($urandom));

        // Start held high: a new op is taken on every DONE cycle.
        @(negedge clk);
        a = $urandom; sh = 5'($urandom); ar = 1'($urandom);
        exp = ref_shift(a, sh, ar);
        bus.start = 1'b1; bus.A = a; bus.s = sh; bus.arith = ar;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk("b2b_busy", 32'(bus.busy), 32'((k % 5) != 0));
            chk("b2b_done", 32'(bus.done), 32'((k % 5) == 0));
            if ((k % 5) == 0) begin
                chk("b2b_B", bus.B, exp);
                a = $urandom; sh = 5'($urandom); ar = 1'($urandom);
                exp = ref_shift(a, sh, ar);
                bus.A = a; bus.s = sh; bus.arith = ar;
                if (k == 15)
                    bus.start = 1'b0;
            end
        end

        // Start while busy is dropped, not queued.
        @(negedge clk);
        bus.start = 1'b1; bus.A = 32'hffff0000; bus.s = 5'd16; bus.arith = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.start = (k == 2);
            if (k == 2) begin
                bus.A = 32'h0; bus.s = 5'd1;
            end
            chk("ign_done", 32'(bus.done), 32'(k == 5));
            chk("ign_busy", 32'(bus.busy), 32'(k < 5));
            if (k >= 5)
                chk("ign_B", bus.B, 32'h0000ffff);
        end

        // Flush mid-operation keeps B and returns to IDLE.
        do_op("pre_flush", 32'h12345678, 5'd0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.A = 32'hcafef00d; bus.s = 5'd3; bus.arith = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.flush = (k == 3);
            chk("fl_busy", 32'(bus.busy), 32'(k <= 3));
            chk("fl_done", 32'(bus.done), 32'd0);
            chk("fl_B", bus.B, 32'h12345678);
        end

        // Flush together with start in IDLE blocks acceptance.
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.A = 32'h1; bus.s = 5'd0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.flush = 1'b0;
            chk("fli_busy", 32'(bus.busy), 32'd0);
            chk("fli_done", 32'(bus.done), 32'd0);
        end

        // Reset in cycle n+2 of an operation.
        @(negedge clk);
        bus.start = 1'b1; bus.A = 32'h0f0f0f0f; bus.s = 5'd2; bus.arith = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_done", 32'(bus.done), 32'd0);
        chk("mrst_B", bus.B, 32'd0);
        do_op("post_rst", 32'h89abcdef, 5'd13, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
